// File: rtl/fetch_ctrl.sv
// fetch_ctrl: IF-stage sequencer handling memory waits, taken-branch redirects, flushes and stall counting.
module fetch_ctrl #(
  parameter int N  = 64,
  parameter int CW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          imem_ready,
  input  logic          stall_D,
  input  logic          branch_taken_M,
  input  logic [N-1:0]  PCBranch_M,
  output logic          imem_req,
  output logic          enable_F,
  output logic          PCSrc_F,
  output logic [N-1:0]  PCBranch_F,
  output logic          valid_F,
  output logic          flush_D,
  output logic          flush_E,
  output logic [CW-1:0] stall_cycles
);
  typedef enum logic [1:0] {BOOT, RUN, PEND} state_t;
  state_t state_q, state_d;
  logic [N-1:0] pend_q;
  logic [CW-1:0] cnt_q;
  logic run, pend;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= BOOT;
      pend_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (run && branch_taken_M && !imem_ready) pend_q <= PCBranch_M;
      if ((run || pend) && !enable_F && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
    end
  end
  always_comb begin
    state_d = reset ? BOOT :
              state_q == BOOT ? RUN :
              state_q == RUN  ? ((branch_taken_M && !imem_ready) ? PEND : RUN) :
              state_q == PEND ? (imem_ready ? RUN : PEND) : BOOT;
  end
  // A redirect overrides a decode stall; a deferred target waits for the outstanding access.
  always_comb begin
    run          = !reset && state_q == RUN;
    pend         = !reset && state_q == PEND;
    imem_req     = run || pend;
    enable_F     = imem_ready && (pend || (run && (branch_taken_M || !stall_D)));
    PCSrc_F      = imem_ready && (pend || (run && branch_taken_M));
    PCBranch_F   = run ? PCBranch_M : pend ? pend_q : '0;
    valid_F      = run && imem_ready && !branch_taken_M && !stall_D;
    flush_D      = run && branch_taken_M;
    flush_E      = run && branch_taken_M;
    stall_cycles = reset ? '0 : cnt_q;
  end
endmodule
